osc_trim_cal: RTL and testbench



---
 rtl/osc_trim_cal.sv | 255 +++++++++++++++++++++++++
 tb/tb_osc_trim_cal.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/osc_trim_cal.sv
// osc_trim_cal: closed-loop trim calibrator for the OSC_32K / OSC_32M oscillators.
// The block counts oscillator edges over a programmable window of clk cycles.
// It then runs an MSB-first successive-approximation search for the largest trim
// code whose edge count does not exceed the target. One final measurement is
// taken at the chosen code, and cal_ok reports whether that count is within tol.
// Optional build macro OSC_TRIM_CAL_TIMEOUT_EN: any window that ends with a zero
// count aborts the search, parks the oscillator and raises the sticky osc_dead.
module osc_trim_cal #(
  parameter int            CW      = 7,
  parameter int            CNTW    = 16,
  parameter int            WINW    = 16,
  parameter int            SETTLE  = 16,
  parameter logic [CW-1:0] RST_CFG = 7'h40
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            start,
  input  logic [WINW-1:0] window,
  input  logic [CNTW-1:0] target,
  input  logic [CNTW-1:0] tol,
  input  logic            osc_ck,
  output logic            osc_en,
  output logic [CW-1:0]   osc_cfg,
  output logic            busy,
  output logic            done,
  output logic            cal_ok,
  output logic [CNTW-1:0] meas_cnt
`ifdef OSC_TRIM_CAL_TIMEOUT_EN
  ,
  output logic            osc_dead
`endif
);

  // One timer serves both the settle wait and the measurement window.
  localparam int SW = (SETTLE > 1) ? $clog2(SETTLE) : 1;
  localparam int TW = (WINW > SW) ? WINW : SW;
  localparam int IW = (CW > 1) ? $clog2(CW) : 1;
  localparam logic [TW-1:0] SETTLE_M1 = TW'(SETTLE - 1);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_SETTLE = 3'd1,
    S_MEAS   = 3'd2,
    S_DECIDE = 3'd3,
    S_DONE   = 3'd4
  } state_t;

  state_t          r_state;
  state_t          w_state_nxt;
  logic [TW-1:0]   r_tmr;
  logic [WINW-1:0] r_win_m1;
  logic [CNTW-1:0] r_target;
  logic [CNTW-1:0] r_tol;
  logic [CNTW-1:0] r_cnt;
  logic [IW-1:0]   r_idx;
  logic            r_final;
  logic            r_sync1;
  logic            r_sync2;
  logic            r_sync3;
  logic            r_osc_en;
  logic [CW-1:0]   r_osc_cfg;
  logic            r_busy;
  logic            r_done;
  logic            r_cal_ok;
  logic [CNTW-1:0] r_meas_cnt;
  logic            r_dead;

  logic            w_edge;
  logic            w_settle_end;
  logic            w_meas_end;
  logic            w_abort;
  logic [CW-1:0]   w_bit;
  logic [CW-1:0]   w_cfg_trial;
  logic [CNTW:0]   w_diff;
  logic [CNTW:0]   w_abs;
  logic            w_in_tol;

  // The first trial code has only the MSB set.
  localparam logic [CW-1:0] MSB_CFG = {1'b1, {(CW-1){1'b0}}};

  assign w_edge       = r_sync2 & ~r_sync3;
  assign w_settle_end = (r_state == S_SETTLE) && (r_tmr == SETTLE_M1);
  assign w_meas_end   = (r_state == S_MEAS) && (r_tmr == TW'(r_win_m1));

`ifdef OSC_TRIM_CAL_TIMEOUT_EN
  assign w_abort  = (r_cnt == {CNTW{1'b0}});
  assign osc_dead = r_dead;
`else
  assign w_abort  = 1'b0;
`endif

  // Search step: drop the bit under test when the count overshot, then try the next lower bit.
  // At idx 0 the shifted-down trial bit is zero, so the same expression yields the final code.
  assign w_bit       = {{(CW-1){1'b0}}, 1'b1} << r_idx;
  assign w_cfg_trial = (r_osc_cfg & ~((r_cnt > r_target) ? w_bit : {CW{1'b0}})) | (w_bit >> 1);

  // |count - target| is formed in CNTW+1 bits so the sign of the difference survives.
  assign w_diff   = {1'b0, r_cnt} - {1'b0, r_target};
  assign w_abs    = w_diff[CNTW] ? ({(CNTW+1){1'b0}} - w_diff) : w_diff;
  assign w_in_tol = (w_abs <= {1'b0, r_tol});

  assign osc_en   = r_osc_en;
  assign osc_cfg  = r_osc_cfg;
  assign busy     = r_busy;
  assign done     = r_done;
  assign cal_ok   = r_cal_ok;
  assign meas_cnt = r_meas_cnt;

  // FSM state register.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // FSM next-state logic.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: begin
        if (start) begin
          w_state_nxt = S_SETTLE;
        end else begin
          w_state_nxt = S_IDLE;
        end
      end
      S_SETTLE: begin
        if (w_settle_end) begin
          w_state_nxt = S_MEAS;
        end else begin
          w_state_nxt = S_SETTLE;
        end
      end
      S_MEAS: begin
        if (w_meas_end) begin
          w_state_nxt = S_DECIDE;
        end else begin
          w_state_nxt = S_MEAS;
        end
      end
      S_DECIDE: begin
        if (w_abort || r_final) begin
          w_state_nxt = S_DONE;
        end else begin
          w_state_nxt = S_SETTLE;
        end
      end
      S_DONE:  w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // osc_ck synchronizer plus a third flop for rising-edge detection.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_sync1 <= 1'b0;
      r_sync2 <= 1'b0;
      r_sync3 <= 1'b0;
    end else begin
      r_sync1 <= osc_ck;
      r_sync2 <= r_sync1;
      r_sync3 <= r_sync2;
    end
  end

  // Settle/window timer, restarted at every phase boundary.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_tmr <= {TW{1'b0}};
    end else if ((r_state == S_SETTLE || r_state == S_MEAS) && (w_state_nxt == r_state)) begin
      r_tmr <= r_tmr + TW'(1);
    end else begin
      r_tmr <= {TW{1'b0}};
    end
  end

  // Saturating edge counter: cleared on entry to MEAS, counts only while in MEAS.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_cnt <= {CNTW{1'b0}};
    end else if (w_settle_end) begin
      r_cnt <= {CNTW{1'b0}};
    end else if ((r_state == S_MEAS) && w_edge && (r_cnt != {CNTW{1'b1}})) begin
      r_cnt <= r_cnt + CNTW'(1);
    end else begin
      r_cnt <= r_cnt;
    end
  end

  // Start capture, trim search and the registered status outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_win_m1   <= {WINW{1'b0}};
      r_target   <= {CNTW{1'b0}};
      r_tol      <= {CNTW{1'b0}};
      r_idx      <= {IW{1'b0}};
      r_final    <= 1'b0;
      r_osc_en   <= 1'b0;
      r_osc_cfg  <= RST_CFG;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_cal_ok   <= 1'b0;
      r_meas_cnt <= {CNTW{1'b0}};
      r_dead     <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_win_m1  <= (window == {WINW{1'b0}}) ? {WINW{1'b0}} : (window - WINW'(1));
            r_target  <= target;
            r_tol     <= tol;
            r_idx     <= IW'(CW - 1);
            r_final   <= 1'b0;
            r_osc_en  <= 1'b1;
            r_osc_cfg <= MSB_CFG;
            r_busy    <= 1'b1;
            r_cal_ok  <= 1'b0;
            r_dead    <= 1'b0;
          end else begin
            r_busy <= r_busy;
          end
        end
        S_DECIDE: begin
          r_meas_cnt <= r_cnt;
          if (w_abort) begin
            r_osc_cfg <= RST_CFG;
            r_osc_en  <= 1'b0;
            r_dead    <= 1'b1;
            r_done    <= 1'b1;
            r_busy    <= 1'b0;
            r_cal_ok  <= 1'b0;
          end else if (r_final) begin
            r_done   <= 1'b1;
            r_busy   <= 1'b0;
            r_cal_ok <= w_in_tol;
          end else begin
            r_osc_cfg <= w_cfg_trial;
            if (r_idx == {IW{1'b0}}) begin
              r_final <= 1'b1;
            end else begin
              r_idx <= r_idx - IW'(1);
            end
          end
        end
        default: begin
          r_busy <= r_busy;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_osc_trim_cal.sv
// Directed bench for osc_trim_cal. The oscillator model emits exactly osc_cfg
// rising edges in any 1280 consecutive clk cycles, using a phase accumulator.
// Mode 1 is a square wave with a period of 2 clk cycles. Mode 2 holds osc_ck low.
module tb_osc_trim_cal;

  localparam int M     = 16 + 1280 + 1;
  localparam int LIMIT = 12000;

  logic        clk;
  logic        reset;
  logic        start;
  logic [15:0] window;
  logic [15:0] target;
  logic [15:0] tol;
  logic        osc_ck;
  logic        osc_en;
  logic [6:0]  osc_cfg;
  logic        busy;
  logic        done;
  logic        cal_ok;
  logic [15:0] meas_cnt;
`ifdef OSC_TRIM_CAL_TIMEOUT_EN
  logic        osc_dead;
`endif

  int n_cmp;
  int n_bad;
  int osc_mode;
  int acc;
  int cyc;
  int nd;

  osc_trim_cal dut (
    .clk      (clk),
    .reset    (reset),
    .start    (start),
    .window   (window),
    .target   (target),
    .tol      (tol),
    .osc_ck   (osc_ck),
    .osc_en   (osc_en),
    .osc_cfg  (osc_cfg),
    .busy     (busy),
    .done     (done),
    .cal_ok   (cal_ok),
    .meas_cnt (meas_cnt)
`ifdef OSC_TRIM_CAL_TIMEOUT_EN
    ,
    .osc_dead (osc_dead)
`endif
  );

  always #5 clk = ~clk;

  // Oscillator model, updated on the falling edge so that clk samples it cleanly.
  always @(negedge clk) begin
    case (osc_mode)
      0: begin
        osc_ck = 1'b0;
        if (osc_en) begin
          acc = acc + int'(osc_cfg);
          if (acc >= 1280) begin
            acc    = acc - 1280;
            osc_ck = 1'b1;
          end
        end else begin
          acc = 0;
        end
      end
      1:       osc_ck = ~osc_ck;
      default: osc_ck = 1'b0;
    endcase
  end

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Pulse start and wait for done. Optionally re-pulse start mid-run.
  // Returns the cycle of done and the number of done pulses seen.
  task automatic do_cal(input logic [15:0] win, input logic [15:0] tgt, input logic [15:0] tl,
                        input int restart_at, output int c, output int ndone);
    window = win;
    target = tgt;
    tol    = tl;
    start  = 1'b1;
    c      = 0;
    ndone  = 0;
    @(posedge clk);
    #1;
    start = 1'b0;
    c     = 1;
    check_val("start_busy", 32'(busy), 32'd1);
    check_val("start_en", 32'(osc_en), 32'd1);
    check_val("start_cfg", 32'(osc_cfg), 32'h40);
    check_val("start_calok_clr", 32'(cal_ok), 32'd0);
`ifdef OSC_TRIM_CAL_TIMEOUT_EN
    check_val("start_dead_clr", 32'(osc_dead), 32'd0);
`endif
    while (done !== 1'b1 && c < LIMIT) begin
      start = (c == restart_at) ? 1'b1 : 1'b0;
      @(posedge clk);
      #1;
      c++;
    end
    start = 1'b0;
    if (c >= LIMIT) check_val("done_timeout", 32'(c), 32'(LIMIT - 1));
    for (int k = 0; k < 6; k++) begin
      if (done === 1'b1) ndone++;
      @(posedge clk);
      #1;
    end
    check_val("after_busy", 32'(busy), 32'd0);
  endtask

  initial begin
    n_cmp    = 0;
    n_bad    = 0;
    acc      = 0;
    osc_mode = 0;
    clk      = 1'b0;
    osc_ck   = 1'b0;
    reset    = 1'b1;
    start    = 1'b1;
    window   = 16'd1280;
    target   = 16'd0;
    tol      = 16'd0;
    repeat (3) @(posedge clk);
    #1;
    start = 1'b0;
    check_val("rst_en", 32'(osc_en), 32'd0);
    check_val("rst_cfg", 32'(osc_cfg), 32'h40);
    check_val("rst_busy", 32'(busy), 32'd0);
    check_val("rst_done", 32'(done), 32'd0);
    check_val("rst_calok", 32'(cal_ok), 32'd0);
    check_val("rst_meas", 32'(meas_cnt), 32'd0);
    reset = 1'b0;
    repeat (2) @(posedge clk);
    #1;

    // Target 45: exact hit.
    do_cal(16'd1280, 16'd45, 16'd1, -1, cyc, nd);
    check_val("t45_lat", 32'(cyc), 32'(8 * M + 1));
    check_val("t45_cfg", 32'(osc_cfg), 32'd45);
    check_val("t45_meas", 32'(meas_cnt), 32'd45);
    check_val("t45_calok", 32'(cal_ok), 32'd1);
    check_val("t45_ndone", 32'(nd), 32'd1);
    check_val("t45_en", 32'(osc_en), 32'd1);

    // Target above the reachable range: saturate at all-ones.
    do_cal(16'd1280, 16'd200, 16'd2, -1, cyc, nd);
    check_val("t200_lat", 32'(cyc), 32'(8 * M + 1));
    check_val("t200_cfg", 32'(osc_cfg), 32'd127);
    check_val("t200_meas", 32'(meas_cnt), 32'd127);
    check_val("t200_calok", 32'(cal_ok), 32'd0);

`ifndef OSC_TRIM_CAL_TIMEOUT_EN
    // Target 0, with a second start while busy that must be ignored.
    do_cal(16'd1280, 16'd0, 16'd1, 100, cyc, nd);
    check_val("t0_lat", 32'(cyc), 32'(8 * M + 1));
    check_val("t0_cfg", 32'(osc_cfg), 32'd0);
    check_val("t0_meas", 32'(meas_cnt), 32'd0);
    check_val("t0_calok", 32'(cal_ok), 32'd1);
    check_val("t0_ndone", 32'(nd), 32'd1);
`endif

    // Reset in the middle of the third measurement window.
    window = 16'd1280;
    target = 16'd45;
    tol    = 16'd1;
    start  = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (2 * M + 16 + 600) @(posedge clk);
    #1;
    check_val("pre_rst_busy", 32'(busy), 32'd1);
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    check_val("mid_rst_en", 32'(osc_en), 32'd0);
    check_val("mid_rst_cfg", 32'(osc_cfg), 32'h40);
    check_val("mid_rst_busy", 32'(busy), 32'd0);
    check_val("mid_rst_done", 32'(done), 32'd0);
    nd = 0;
    for (int k = 0; k < 50; k++) begin
      if (done === 1'b1) nd++;
      @(posedge clk);
      #1;
    end
    check_val("mid_rst_nodone", 32'(nd), 32'd0);
    do_cal(16'd1280, 16'd45, 16'd1, -1, cyc, nd);
    check_val("re_lat", 32'(cyc), 32'(8 * M + 1));
    check_val("re_cfg", 32'(osc_cfg), 32'd45);
    check_val("re_calok", 32'(cal_ok), 32'd1);

`ifndef OSC_TRIM_CAL_TIMEOUT_EN
    // Window 0 behaves as 1; an oscillator period of 2 gives counts of 0 or 1.
    osc_mode = 1;
    do_cal(16'd0, 16'd1, 16'd1, -1, cyc, nd);
    check_val("w0_lat", 32'(cyc), 32'(8 * (16 + 1 + 1) + 1));
    check_val("w0_cfg", 32'(osc_cfg), 32'd127);
    check_val("w0_cnt_le1", 32'(meas_cnt <= 16'd1), 32'd1);
    check_val("w0_calok", 32'(cal_ok), 32'd1);
    osc_mode = 0;
`endif

`ifdef OSC_TRIM_CAL_TIMEOUT_EN
    // Dead oscillator: abort after the first window.
    osc_mode = 2;
    do_cal(16'd1280, 16'd45, 16'd1, -1, cyc, nd);
    check_val("dead_lat", 32'(cyc), 32'(M + 1));
    check_val("dead_flag", 32'(osc_dead), 32'd1);
    check_val("dead_en", 32'(osc_en), 32'd0);
    check_val("dead_cfg", 32'(osc_cfg), 32'h40);
    check_val("dead_calok", 32'(cal_ok), 32'd0);
    check_val("dead_ndone", 32'(nd), 32'd1);
    osc_mode = 0;
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
